// File: rtl/tiny_dnn_pkg.sv
// Shared types and constants for the tiny_dnn sequencer.
package tiny_dnn_pkg;

  typedef enum logic [3:0] {
    IDLE, LOAD, INIT, RUN, BIAS, WAIT, NORM, CAPT, OUT
  } seq_state_t;

  localparam logic [15:0] BF16_ONE  = 16'h3F80;
  localparam int          BIAS_WAIT = 2;

endpackage

// File: rtl/fp32_to_bf16.sv
// Combinational fp32 -> bf16 conversion, round-to-nearest-even.
module fp32_to_bf16 (
  input  logic [31:0] fp32_i,
  output logic [15:0] bf16_o
);

  logic round_up;

  // A mantissa carry ripples into the exponent; overflow lands on +/-inf.
  assign round_up = fp32_i[15] & ((|fp32_i[14:0]) | fp32_i[16]);
  assign bf16_o   = fp32_i[31:16] + {15'd0, round_up};

endmodule

// File: rtl/tiny_dnn_seq.sv
// Sequencer for one tiny_dnn_core + normalize: weight load, dot product, bf16 result.
// Optional feature: define TINY_DNN_RELU_EN to clamp negative results to zero.
//
// state | meaning
// IDLE  | waiting for cmd_load / cmd_run
// LOAD  | streaming n weights then the bias word into the core
// INIT  | one-cycle core accumulator clear
// RUN   | streaming n activations, one exec per handshake
// BIAS  | one-cycle bias add
// WAIT  | BIAS_WAIT cycles for the accumulator pipeline to drain
// NORM  | one-cycle normalize enable
// CAPT  | round nrm into the output register
// OUT   | result held on out_data until out_ready
module tiny_dnn_seq
  import tiny_dnn_pkg::*;
#(
  parameter int F_SIZE = 1024
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        cmd_load_i,
  input  logic        cmd_run_i,
  input  logic [9:0]  n_in_i,
  output logic        busy_o,
  input  logic        wt_valid_i,
  output logic        wt_ready_o,
  input  logic [15:0] wt_data_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [15:0] in_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [15:0] out_data_o,
  output logic        init_o,
  output logic        exec_o,
  output logic        bias_o,
  output logic        write_o,
  output logic        bwrite_o,
  output logic [9:0]  ra_o,
  output logic [9:0]  wa_o,
  output logic [15:0] d_o,
  output logic [15:0] wd_o,
  output logic        en_o,
  input  logic [31:0] nrm_i
);

  localparam logic [9:0] BIAS_ADDR = 10'(F_SIZE - 1);

  seq_state_t  state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [9:0]  n_q, n_d;
  logic [15:0] d_q, d_d;
  logic [15:0] out_q, out_d;
  logic [15:0] nrm_bf16;

  fp32_to_bf16 u_round (
    .fp32_i (nrm_i),
    .bf16_o (nrm_bf16)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      d_q     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      d_q     <= d_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    d_d     = d_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (cmd_load_i) begin
          n_d     = n_in_i;
          cnt_d   = '0;
          state_d = LOAD;
        end else if (cmd_run_i) begin
          n_d     = n_in_i;
          state_d = INIT;
        end
      end
      LOAD: begin
        if (wt_valid_i) begin
          if (cnt_q == n_q) state_d = IDLE;
          else              cnt_d   = cnt_q + 10'd1;
        end
      end
      INIT: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        if (in_valid_i) begin
          d_d   = in_data_i;
          cnt_d = cnt_q + 10'd1;
          if (cnt_q == n_q - 10'd1) state_d = BIAS;
        end
      end
      BIAS: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 10'(BIAS_WAIT - 1)) state_d = NORM;
        else                             cnt_d   = cnt_q + 10'd1;
      end
      NORM: state_d = CAPT;
      CAPT: begin
`ifdef TINY_DNN_RELU_EN
        out_d = nrm_i[31] ? 16'h0000 : nrm_bf16;
`else
        out_d = nrm_bf16;
`endif
        state_d = OUT;
      end
      OUT: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o      = (state_q != IDLE);
    wt_ready_o  = (state_q == LOAD);
    write_o     = (state_q == LOAD) && wt_valid_i;
    bwrite_o    = write_o && (cnt_q == n_q);
    wa_o        = '0;
    wd_o        = '0;
    if (write_o) begin
      wa_o = bwrite_o ? BIAS_ADDR : cnt_q;
      wd_o = wt_data_i;
    end
    in_ready_o  = (state_q == RUN);
    exec_o      = (state_q == RUN) && in_valid_i;
    ra_o        = exec_o ? cnt_q : '0;
    init_o      = (state_q == INIT);
    bias_o      = (state_q == BIAS);
    en_o        = (state_q == NORM);
    out_valid_o = (state_q == OUT);
  end

  assign d_o        = d_q;
  assign out_data_o = out_q;

endmodule

// File: tb/tb_tiny_dnn_seq.sv
// Self-checking bench for tiny_dnn_seq with a behavioural core/normalize model.
module tb_tiny_dnn_seq;
  import tiny_dnn_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_load = 1'b0, cmd_run = 1'b0;
  logic [9:0]  n_in = '0;
  logic        busy;
  logic        wt_valid = 1'b0, wt_ready;
  logic [15:0] wt_data = '0;
  logic        in_valid = 1'b0, in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [15:0] out_data;
  logic        init, exec, bias, write, bwrite, en;
  logic [9:0]  ra, wa;
  logic [15:0] d, wd;
  logic [31:0] nrm = '0;

  int errors = 0;
  int checks = 0;

  logic [15:0] w_a [0:15];
  logic [15:0] x_a [0:15];
  logic [15:0] bias_v;
  logic [6:0]  pat = 7'b1001011;
  logic        ovr_en = 1'b0;
  logic [31:0] ovr_val = '0;

  tiny_dnn_seq dut (
    .clk_i(clk), .reset_i(reset), .cmd_load_i(cmd_load), .cmd_run_i(cmd_run),
    .n_in_i(n_in), .busy_o(busy), .wt_valid_i(wt_valid), .wt_ready_o(wt_ready),
    .wt_data_i(wt_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .init_o(init), .exec_o(exec), .bias_o(bias),
    .write_o(write), .bwrite_o(bwrite), .ra_o(ra), .wa_o(wa), .d_o(d),
    .wd_o(wd), .en_o(en), .nrm_i(nrm)
  );

  always #5 clk = ~clk;

  function automatic real bf16_to_real(input logic [15:0] b);
    real m;
    int  e;
    if (b[14:0] == 15'd0) return 0.0;
    m = 1.0 + real'(b[6:0]) / 128.0;
    e = int'(b[14:7]) - 127;
    m = m * (2.0 ** real'(e));
    return b[15] ? -m : m;
  endfunction

  function automatic logic [31:0] real_to_fp32(input real r);
    logic [63:0] bits;
    int          e;
    if (r == 0.0) return 32'd0;
    bits = $realtobits(r);
    e = int'(bits[62:52]) - 1023 + 127;
    return {bits[63], 8'(e), bits[51:29]};
  endfunction

  function automatic logic [15:0] int_to_bf16(input int k);
    logic [31:0] f;
    f = real_to_fp32(real'(k));
    return f[31:16];
  endfunction

  function automatic logic [15:0] rne(input logic [31:0] f);
    logic [15:0] hi, lo;
    hi = f[31:16];
    lo = f[15:0];
    if (lo > 16'h8000 || (lo == 16'h8000 && hi[0])) return hi + 16'd1;
    return hi;
  endfunction

  function automatic logic [15:0] expect_out(input logic [31:0] f);
`ifdef TINY_DNN_RELU_EN
    if (f[31]) return 16'h0000;
`endif
    return rne(f);
  endfunction

  function automatic logic [31:0] dot_fp32(input int n);
    real s;
    s = bf16_to_real(bias_v);
    for (int i = 0; i < n; i++) s = s + bf16_to_real(w_a[i]) * bf16_to_real(x_a[i]);
    return real_to_fp32(s);
  endfunction

  // Core + normalize model: weight memory, exec/d product with one-cycle d lag,
  // bias add, and nrm presented the cycle after en.
  real         mem [0:1023];
  real         acc = 0.0;
  logic        pend = 1'b0;
  logic [9:0]  pend_ra = '0;
  logic        armed = 1'b0;
  int          exec_cnt = 0, init_cnt = 0, write_cnt = 0, bwrite_cnt = 0, bad_exec = 0;

  always @(posedge clk) begin
    if (write) mem[wa] <= bf16_to_real(wd);
    if (init) acc <= 0.0;
    else acc <= acc + (pend ? mem[pend_ra] * bf16_to_real(d) : 0.0)
                    + (bias ? mem[1023] : 0.0);
    pend    <= exec;
    pend_ra <= ra;
    if (en) nrm <= ovr_en ? ovr_val : real_to_fp32(acc);
    exec_cnt   <= exec_cnt + (exec ? 1 : 0);
    init_cnt   <= init_cnt + (init ? 1 : 0);
    write_cnt  <= write_cnt + (write ? 1 : 0);
    bwrite_cnt <= bwrite_cnt + (bwrite ? 1 : 0);
    if (reset) armed <= 1'b0;
    else if (init) armed <= 1'b1;
    else if (bias) armed <= 1'b0;
    if (exec && !armed) bad_exec <= bad_exec + 1;
  end

  task automatic load_seq(input int n, output logic ok);
    int i, guard;
    logic hs;
    i = 0; guard = 0;
    @(negedge clk); cmd_load = 1'b1; n_in = 10'(n);
    @(negedge clk); cmd_load = 1'b0;
    while (i <= n && guard < 200) begin
      wt_valid = 1'b1;
      wt_data  = (i < n) ? w_a[i] : bias_v;
      hs = wt_ready;
      @(negedge clk);
      if (hs) i++;
      guard++;
    end
    wt_valid = 1'b0;
    ok = (i > n);
  endtask

  task automatic run_seq(input int n, input int mode, output logic [15:0] res,
                         output int lat, output logic ok);
    int i, p;
    logic v, hs;
    i = 0; p = 0; lat = 0;
    @(negedge clk); cmd_run = 1'b1; n_in = 10'(n);
    @(negedge clk); cmd_run = 1'b0; lat = 1;
    while (!out_valid && lat < 300) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = pat[6 - (p % 7)];
        default: v = 1'($urandom_range(0, 1));
      endcase
      hs = in_ready;
      if (hs) p++;
      if (v && i < n) begin in_valid = 1'b1; in_data = x_a[i]; end
      else in_valid = 1'b0;
      if (hs && v && i < n) i++;
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    ok  = out_valid;
    res = out_data;
  endtask

  task automatic finish_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic set_case1();
    for (int i = 0; i < 4; i++) begin w_a[i] = BF16_ONE; x_a[i] = BF16_ONE; end
    bias_v = BF16_ONE;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, wt_ready, in_ready, out_valid, init, exec, bias, write, bwrite, en,
         ra, wa, d, wd, out_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%0b out_valid=%0b out_data=%h d=%h expected all zero",
               busy, out_valid, out_data, d);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy=%0b expected 0", busy); end
  endtask

  task automatic test_load_run();
    logic ok; logic [15:0] res; int lat, w0, b0, e0;
    set_case1();
    w0 = write_cnt; b0 = bwrite_cnt;
    load_seq(4, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL load_timeout: handshakes incomplete"); end
    @(negedge clk);
    checks++;
    if (write_cnt - w0 !== 5 || bwrite_cnt - b0 !== 1) begin
      errors++;
      $display("FAIL load_writes: writes=%0d bwrites=%0d expected 5 and 1", write_cnt - w0, bwrite_cnt - b0);
    end
    e0 = exec_cnt;
    run_seq(4, 0, res, lat, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL run1_timeout: no out_valid"); end
    checks++;
    if (res !== expect_out(dot_fp32(4)) || res !== 16'h40A0) begin
      errors++; $display("FAIL run1_result: got %h expected %h", res, 16'h40A0);
    end
    checks++;
    if (lat !== 11) begin errors++; $display("FAIL run1_latency: got %0d expected 11", lat); end
    checks++;
    if (exec_cnt - e0 !== 4) begin errors++; $display("FAIL run1_execs: got %0d expected 4", exec_cnt - e0); end
    finish_out();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL run1_idle: busy=%0b expected 0", busy); end
  endtask

  task automatic test_gaps();
    logic ok; logic [15:0] res; int lat, e0;
    e0 = exec_cnt;
    run_seq(4, 1, res, lat, ok);
    checks++;
    if (!ok || res !== 16'h40A0) begin
      errors++; $display("FAIL gaps_result: got %h valid=%0b expected 40a0", res, ok);
    end
    checks++;
    if (exec_cnt - e0 !== 4) begin errors++; $display("FAIL gaps_execs: got %0d expected 4", exec_cnt - e0); end
    finish_out();
  endtask

  task automatic test_hold();
    logic ok; logic [15:0] res; int lat, i0;
    run_seq(4, 0, res, lat, ok);
    i0 = init_cnt;
    for (int h = 0; h < 10; h++) begin
      cmd_run  = h[0];
      cmd_load = (h == 5);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h40A0) begin
        errors++;
        $display("FAIL hold_stable: cycle %0d out_valid=%0b out_data=%h expected 1 and 40a0", h, out_valid, out_data);
      end
    end
    cmd_run = 1'b0; cmd_load = 1'b0;
    checks++;
    if (init_cnt - i0 !== 0) begin errors++; $display("FAIL hold_ignore_cmd: inits=%0d expected 0", init_cnt - i0); end
    finish_out();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL hold_release: busy=%0b expected 0", busy); end
  endtask

  task automatic test_reset_abort();
    logic ok, hs; logic [15:0] res; int lat, i, guard, b0, i0;
    i = 0; guard = 0;
    @(negedge clk); cmd_run = 1'b1; n_in = 10'd4;
    @(negedge clk); cmd_run = 1'b0;
    while (i < 2 && guard < 20) begin
      in_valid = 1'b1; in_data = x_a[i];
      hs = in_ready;
      @(negedge clk);
      if (hs) i++;
      guard++;
    end
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL abort_idle: busy=%0b out_valid=%0b expected 0", busy, out_valid);
    end
    b0 = bad_exec; i0 = init_cnt;
    run_seq(4, 0, res, lat, ok);
    checks++;
    if (!ok || res !== 16'h40A0) begin
      errors++; $display("FAIL abort_rerun: got %h valid=%0b expected 40a0", res, ok);
    end
    checks++;
    if (bad_exec - b0 !== 0 || init_cnt - i0 !== 1) begin
      errors++;
      $display("FAIL abort_init_order: stray_execs=%0d inits=%0d expected 0 and 1", bad_exec - b0, init_cnt - i0);
    end
    finish_out();
  endtask

  task automatic test_negative();
    logic ok; logic [15:0] res, exp_v; int lat;
    w_a[0] = 16'hBF80; w_a[1] = 16'hBF80; bias_v = BF16_ONE;
    x_a[0] = 16'h4000; x_a[1] = 16'h4000;
    load_seq(2, ok);
    run_seq(2, 0, res, lat, ok);
`ifdef TINY_DNN_RELU_EN
    exp_v = 16'h0000;
`else
    exp_v = 16'hC040;
`endif
    checks++;
    if (!ok || res !== exp_v || res !== expect_out(dot_fp32(2))) begin
      errors++; $display("FAIL negative_result: got %h expected %h", res, exp_v);
    end
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL negative_latency: got %0d expected 9", lat); end
    finish_out();
  endtask

  task automatic test_rounding();
    logic ok; logic [15:0] res; int lat;
    logic [31:0] vals [0:13];
    vals[0] = 32'h3F808000; vals[1] = 32'h3F818000; vals[2] = 32'h3F80C000;
    vals[3] = 32'h3FFF8001; vals[4] = 32'h7F7F8000; vals[5] = 32'h00000000;
    for (int k = 6; k < 14; k++) vals[k] = $urandom;
    ovr_en = 1'b1;
    for (int k = 0; k < 14; k++) begin
      ovr_val = vals[k];
      run_seq(1, 0, res, lat, ok);
      checks++;
      if (!ok || res !== expect_out(vals[k])) begin
        errors++; $display("FAIL round_%0d: nrm=%h got %h expected %h", k, vals[k], res, expect_out(vals[k]));
      end
      finish_out();
    end
    ovr_en = 1'b0;
  endtask

  task automatic test_random();
    logic ok; logic [15:0] res; int lat, n, e0;
    for (int it = 0; it < 6; it++) begin
      n = int'($urandom_range(1, 8));
      for (int i = 0; i < n; i++) begin
        w_a[i] = int_to_bf16(int'($urandom_range(0, 6)) - 3);
        x_a[i] = int_to_bf16(int'($urandom_range(0, 6)) - 3);
      end
      bias_v = int_to_bf16(int'($urandom_range(0, 6)) - 3);
      load_seq(n, ok);
      e0 = exec_cnt;
      run_seq(n, 2, res, lat, ok);
      checks++;
      if (!ok || res !== expect_out(dot_fp32(n))) begin
        errors++; $display("FAIL random_%0d: n=%0d got %h expected %h", it, n, res, expect_out(dot_fp32(n)));
      end
      checks++;
      if (exec_cnt - e0 !== n) begin
        errors++; $display("FAIL random_execs_%0d: got %0d expected %0d", it, exec_cnt - e0, n);
      end
      finish_out();
    end
  endtask

  initial begin
    test_reset();
    test_load_run();
    test_gaps();
    test_hold();
    test_reset_abort();
    test_negative();
    test_rounding();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tiny_dnn_seq.md
# tiny_dnn_seq

Sequencer that drives one `tiny_dnn_core` plus its `normalize` stage. It streams weights into the core's weight memory, then streams bfloat16 activations into the core for a dot product of `n_in` terms plus bias. It reads the normalized fp32 result, rounds it to bfloat16 and presents it on a valid/ready output. It is the initiator side of the core's `init/exec/bias/ra/d/write` interface and the consumer of `normalize.nrm`.

## Interface
Parameters:
- `F_SIZE`, 1024: core weight depth; address `F_SIZE-1` is the bias slot.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high; one clock, synchronous active-high reset.
- `cmd_load` in 1: start a weight load; sampled only in IDLE.
- `cmd_run` in 1: start a dot product; sampled only in IDLE; `cmd_load` wins if both are set.
- `n_in` in 10: term count, 1..`F_SIZE`-1; latched at command.
- `busy` out 1: high when not in IDLE.
- `wt_valid`/`wt_ready` in/out 1: weight stream handshake.
- `wt_data` in 16: weight or bias word (bf16).
- `in_valid`/`in_ready` in/out 1: activation stream handshake.
- `in_data` in 16: activation (bf16).
- `out_valid`/`out_ready` out/in 1: result stream handshake.
- `out_data` out 16: result (bf16).
- To core: `init`, `exec`, `bias`, `write`, `bwrite` out 1; `ra`, `wa` out 10; `d`, `wd` out 16.
- To normalize: `en` out 1. From normalize: `nrm` in 32.

## Operation
- Reset values: all outputs 0; state IDLE; counter 0.
- **IDLE**
  - On `cmd_load`: latch `n_in`, counter=0, go to LOAD.
  - Else on `cmd_run`: latch `n_in`, go to INIT.
- **LOAD**
  - `wt_ready`=1.
  - Each handshake while counter<n: `write`=1, `wa`=counter, `wd`=`wt_data`, counter++.
  - When counter==n, the next handshake writes bias: `write`=1, `bwrite`=1. Then go to IDLE.
  - `write` is combinational with the handshake.
- **INIT**: `init`=1 for exactly one cycle, counter=0, then RUN.
- **RUN**
  - `in_ready`=1.
  - On each handshake: `exec`=1, `ra`=counter, the `d` register <= `in_data`, counter++.
  - After the n-th handshake, go to BIAS.
  - Gaps in `in_valid` are legal; the core only accumulates on exec.
- **BIAS**: `bias`=1 for one cycle, then WAIT.
- **WAIT**: two cycles, then NORM.
- **NORM**: `en`=1 for one cycle, then CAPT.
- **CAPT**: `out_data` <= round(`nrm`), then OUT.
- **OUT**
  - `out_valid`=1; `out_data` stays stable.
  - On `out_ready`, go to IDLE.
- **Rounding**: fp32 to bf16, round-to-nearest-even.
  - Increment `nrm[31:16]` when `nrm[15]` & (`nrm[14:0]`!=0 | `nrm[16]`).
  - Mantissa carry propagates into the exponent. Overflow to 0x7F80/0xFF80 is accepted.
  - A `nrm` of 0 gives 0x0000.
- `cmd_*` outside IDLE are ignored; no queuing.
- `reset` in any state aborts. No core `init` is issued. The next RUN always issues INIT first, so stale accumulator content is harmless.

## Timing
- `d` is presented one cycle after its `exec`/`ra`, i.e. aligned with the core's `exec1`.
- `init` precedes the first `exec` by at least one cycle. This keeps `init2` from swallowing the first product.
- Bias issued in cycle b:
  - the accumulator is final in cycle b+3, where `en` is asserted;
  - `nrm` is valid in b+4 and captured;
  - `out_valid` rises in b+5.
- Minimum run latency: `cmd_run` at cycle 0 with `in_valid` held high gives `out_valid` at cycle n+7.
- Load: n+1 handshakes, with no added latency between them.

## Configuration
- `TINY_DNN_RELU_EN` defined: in CAPT, a negative `nrm` (`nrm[31]`=1) produces `out_data`=0x0000.
- Not defined: the signed result is passed unchanged.

## Structure
- Package `tiny_dnn_pkg`:
  - state enum `seq_state_t` (IDLE, LOAD, INIT, RUN, BIAS, WAIT, NORM, CAPT, OUT);
  - constant `BF16_ONE`=16'h3F80;
  - constant `BIAS_WAIT`=2.
- Sub-module `fp32_to_bf16`: combinational round-to-nearest-even, tested standalone.
- The core and `normalize` are instantiated by the parent, not inside this block.

## Test plan
- Load 4 weights of 0x3F80 plus bias 0x3F80, n_in=4; run with 4 inputs of 0x3F80 -> `out_data`=0x40A0 (5.0), `out_valid` at cycle 11.
- Weights 0xBF80 ×2, bias 0x3F80, inputs 0x4000 ×2 -> 0xC040 (-3.0); with `TINY_DNN_RELU_EN` -> 0x0000.
- Same as case 1 with `in_valid` toggling 1-0-0-1-0-1-1 -> same result 0x40A0; `exec` count is exactly 4.
- `out_ready` held low 10 cycles -> `out_valid`/`out_data` stable; `cmd_run` pulses are ignored while busy.
- `reset` asserted in RUN after 2 inputs, then a full run -> correct 0x40A0, and `init` is seen before the first `exec`.
- `fp32_to_bf16` unit cases:
  - 0x3F808000 -> 0x3F80 (tie to even);
  - 0x3F818000 -> 0x3F82;
  - 0x3F80C000 -> 0x3F81.
